// File: rtl/mem_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl_pkg
//
// Shared types and constants for the pipeline memory-stall controller.
//   stall_state_t : registered controller state (IDLE / RUN / WAIT)
//   PORT_IMEM     : channel index of the instruction memory port
//   PORT_DMEM     : channel index of the data memory port
// -----------------------------------------------------------------------------
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // first cycle out of reset, pipeline frozen
        ST_RUN  = 2'b01,  // nothing outstanding
        ST_WAIT = 2'b10   // at least one response outstanding
    } stall_state_t;

    localparam int unsigned PORT_IMEM = 0;
    localparam int unsigned PORT_DMEM = 1;

endpackage : mem_stall_ctrl_pkg

// File: rtl/mem_stall_ctrl_port_tracker.sv
// -----------------------------------------------------------------------------
// mem_port_tracker
//
// Outstanding-request bookkeeping for a single memory channel.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   req_i       : request issued this cycle
//   resp_i      : response returned this cycle
//   move_i      : pipeline advances this cycle (a request only counts if 1)
//   flush_i     : redirect; squash the in-flight response if KILL_EN
//   pend_o      : a response is currently outstanding
//   pend_d_o    : next-cycle value of pend_o (feeds the state decision)
//   resolved_o  : this port does not hold the pipeline this cycle
//   resp_ok_o   : response is valid and is to be consumed
//   squash_o    : a stale response retired and was discarded
// -----------------------------------------------------------------------------
module mem_port_tracker #(
    parameter logic KILL_EN = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic resp_i,
    input  logic move_i,
    input  logic flush_i,
    output logic pend_o,
    output logic pend_d_o,
    output logic resolved_o,
    output logic resp_ok_o,
    output logic squash_o
);

    logic pend_q, pend_d;
    logic drop_q, drop_d;
    logic kill;

    // NOTE: every signal written here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        // The response is stale if a flush is happening now or happened while
        // it was in flight.
        kill       = KILL_EN & (drop_q | flush_i);
        // A same-cycle response and request retires the old one and issues anew.
        pend_d     = (pend_q & ~resp_i) | (req_i & move_i);
        // Drop marker lives only until the stale response comes back.
        drop_d     = pend_q & ~resp_i & kill;
        resolved_o = ~pend_q | resp_i;
        resp_ok_o  = ~rst_i & resp_i & pend_q & ~kill;
        squash_o   = ~rst_i & resp_i & pend_q & kill;
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is sampled on the clock edge like any other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign pend_o   = pend_q;
    assign pend_d_o = pend_d;

endmodule : mem_port_tracker

// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
//
// Pipeline stall controller for NUM_PORTS memory channels. Holds the pipeline
// until every outstanding response has returned, squashes stale responses
// after a redirect, inserts load-use bubbles and counts stall cycles.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   mem_req_i   : per-port request this cycle (legal only while move_o=1)
//   mem_resp_i  : per-port response this cycle
//   flush_i     : branch redirect
//   ld_use_i    : load-use hazard detected in ID
//   move_o      : global pipeline-register enable (combinational)
//   bubble_o    : hold IF/ID, inject NOP into ID/EX (combinational)
//   resp_ok_o   : per-port response valid and to be consumed
//   refetch_o   : a squashed response retired; reissue fetch
//   state_o     : registered controller state
//   stall_cnt_o : saturating count of non-IDLE cycles with move_o=0
//   err_o       : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned                NUM_PORTS  = 2,
    parameter logic [NUM_PORTS-1:0]       FLUSH_MASK = NUM_PORTS'(1),
    parameter int unsigned                CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] mem_req_i,
    input  logic [NUM_PORTS-1:0] mem_resp_i,
    input  logic                 flush_i,
    input  logic                 ld_use_i,
    output logic                 move_o,
    output logic                 bubble_o,
    output logic [NUM_PORTS-1:0] resp_ok_o,
    output logic                 refetch_o,
    output stall_state_t         state_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic                 err_o
);

    stall_state_t         state_q;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic                 err_q;

    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] pend_d;
    logic [NUM_PORTS-1:0] resolved;
    logic [NUM_PORTS-1:0] squash;
    logic                 move;
    logic                 stall;
    logic                 violation;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        mem_port_tracker #(
            .KILL_EN (FLUSH_MASK[g])
        ) u_tracker (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req_i      (mem_req_i[g]),
            .resp_i     (mem_resp_i[g]),
            .move_i     (move),
            .flush_i    (flush_i),
            .pend_o     (pend[g]),
            .pend_d_o   (pend_d[g]),
            .resolved_o (resolved[g]),
            .resp_ok_o  (resp_ok_o[g]),
            .squash_o   (squash[g])
        );
    end

    always_comb begin
        // Gated by reset so a reset issued mid-WAIT freezes the pipeline at once.
        move      = ~rst_i & (state_q != ST_IDLE) & (&resolved);
        stall     = (state_q != ST_IDLE) & ~move;
        // Responses seen in IDLE belong to traffic from before reset.
        violation = ((state_q != ST_IDLE) & (|(mem_resp_i & ~pend)))
                  | ((|mem_req_i) & ~move);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= (|pend_d) ? ST_WAIT : ST_RUN;
            // Saturate at all-ones rather than wrapping.
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    assign move_o      = move;
    assign bubble_o    = move & ld_use_i;
    assign refetch_o   = |squash;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule : mem_stall_ctrl
